// File: rtl/cosim_xfer_sched.sv
// Co-simulation transfer scheduler: arbitrates a host write stream and a
// device-to-host read burst engine onto one credit-limited endpoint port,
// tracking in-order responses so read data is returned to the host.
module cosim_xfer_sched #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int LEN_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_val,
  output logic              wr_rdy,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              rd_val,
  output logic              rd_rdy,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              rd_resp_val,
  output logic              rd_resp_last,
  output logic [ADDR_W-1:0] ep_addr,
  output logic [DATA_W-1:0] ep_data,
  output logic              ep_we,
  output logic              ep_val,
  input  logic              ep_rdy,
  input  logic [DATA_W-1:0] ep_resp_data,
  input  logic              ep_resp_val,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int PW = $clog2(MAX_OUT);
  localparam logic [CW-1:0] CRED_FULL = CW'(MAX_OUT);

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rstate_t;
  typedef enum logic {SIDE_WR, SIDE_RD} side_t;

  rstate_t           state, state_nxt;
  side_t             rr;
  logic [CW-1:0]     credits;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  issue_left;
  logic [LEN_W-1:0]  resp_left;
  logic [MAX_OUT-1:0] tag_mem;
  logic [PW-1:0]     tag_wp, tag_rp;
  logic              wr_elig, rd_elig, gnt_wr, gnt_rd;
  logic              ep_fire, rd_issue, resp_ok, burst_start;

  // Grant: single eligible side wins; on contention the rr pointer decides.
  always_comb begin
    wr_elig  = wr_val & (credits != '0);
    rd_elig  = (state == R_ISSUE) & (credits != '0);
    gnt_rd   = rd_elig & (~wr_elig | (rr == SIDE_RD));
    gnt_wr   = wr_elig & ~gnt_rd;
    ep_val   = gnt_wr | gnt_rd;
    ep_we    = gnt_wr;
    ep_addr  = gnt_rd ? rd_addr : wr_addr;
    ep_data  = gnt_wr ? wr_data : '0;
    ep_fire  = ep_val & ep_rdy;
    rd_issue = gnt_rd & ep_rdy;
    wr_rdy   = gnt_wr & ep_rdy;
  end

  // Response routing: the tag at the FIFO head says whether this is read data.
  always_comb begin
    resp_ok      = ep_resp_val & (credits != CRED_FULL);
    rd_resp_val  = resp_ok & tag_mem[tag_rp];
    rd_resp_last = rd_resp_val & (resp_left == LEN_W'(1));
    rd_resp_data = rd_resp_val ? ep_resp_data : '0;
    busy         = (state != R_IDLE) | (credits != CRED_FULL);
  end

  // Read burst FSM next-state and burst handshake.
  always_comb begin
    state_nxt   = state;
    rd_rdy      = 1'b0;
    burst_start = 1'b0;
    case (state)
      R_IDLE: begin
        rd_rdy = 1'b1;
        if (rd_val && (rd_len != '0)) begin
          burst_start = 1'b1;
          state_nxt   = R_ISSUE;
        end
      end
      R_ISSUE: if (rd_issue && (issue_left == LEN_W'(1))) state_nxt = R_DRAIN;
      R_DRAIN: if (resp_left == '0) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= R_IDLE;
    else       state <= state_nxt;
  end

  // Burst address and issue/response countdowns.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr    <= '0;
      issue_left <= '0;
      resp_left  <= '0;
    end else if (burst_start) begin
      rd_addr    <= rd_base;
      issue_left <= rd_len;
      resp_left  <= rd_len;
    end else begin
      if (rd_issue) begin
        rd_addr    <= rd_addr + ADDR_W'(4);
        issue_left <= issue_left - LEN_W'(1);
      end
      if (rd_resp_val) resp_left <= resp_left - LEN_W'(1);
    end
  end

  // Credits, round-robin pointer and sticky protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= CRED_FULL;
      rr      <= SIDE_WR;
      err     <= 1'b0;
    end else begin
      credits <= credits - {{(CW-1){1'b0}}, ep_fire} + {{(CW-1){1'b0}}, resp_ok};
      if (ep_fire) rr <= gnt_wr ? SIDE_RD : SIDE_WR;
      if (ep_resp_val && !resp_ok) err <= 1'b1;
    end
  end

  // Tag FIFO; credits bound its occupancy so no full/empty flags are needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_mem <= '0;
      tag_wp  <= '0;
      tag_rp  <= '0;
    end else begin
      if (ep_fire) begin
        tag_mem[tag_wp] <= gnt_rd;
        tag_wp          <= tag_wp + PW'(1);
      end
      if (resp_ok) tag_rp <= tag_rp + PW'(1);
    end
  end

endmodule

// File: tb/tb_cosim_xfer_sched.sv
// Testbench for cosim_xfer_sched: queue-based transaction model of the
// scheduler with a behavioural endpoint that answers reads with addr>>2.
module tb_cosim_xfer_sched;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wr_addr, wr_data, rd_base, rd_resp_data, ep_addr, ep_data, ep_resp_data;
  logic        wr_val, wr_rdy, rd_val, rd_rdy, rd_resp_val, rd_resp_last;
  logic [8:0]  rd_len;
  logic        ep_we, ep_val, ep_rdy, ep_resp_val, busy, err;

  cosim_xfer_sched #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAXO), .LEN_W(9)) dut (
    .clk(clk), .reset(reset),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_val(wr_val), .wr_rdy(wr_rdy),
    .rd_base(rd_base), .rd_len(rd_len), .rd_val(rd_val), .rd_rdy(rd_rdy),
    .rd_resp_data(rd_resp_data), .rd_resp_val(rd_resp_val), .rd_resp_last(rd_resp_last),
    .ep_addr(ep_addr), .ep_data(ep_data), .ep_we(ep_we), .ep_val(ep_val), .ep_rdy(ep_rdy),
    .ep_resp_data(ep_resp_data), .ep_resp_val(ep_resp_val),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ep_val;
    logic        ep_we;
    logic [31:0] ep_addr;
    logic [31:0] ep_data;
    logic        wr_rdy;
    logic        rd_rdy;
    logic        rd_resp_val;
    logic        rd_resp_last;
    logic [31:0] rd_resp_data;
    logic        busy;
    logic        err;
  } obs_t;

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model state
  int          cred;
  bit          q_isrd[$];
  logic [31:0] q_addr[$];
  logic [31:0] rd_order[$];
  bit          active;
  int          issue_left;
  logic [31:0] next_addr;
  bit          pref_rd;
  bit          m_err;
  bit          p_gwr, p_grd, p_fire, p_ok;

  obs_t e, o;

  task automatic model_reset();
    cred = MAXO;
    q_isrd.delete(); q_addr.delete(); rd_order.delete();
    active = 0; issue_left = 0; next_addr = '0; pref_rd = 0; m_err = 0;
  endtask

  function automatic obs_t observe();
    obs_t r;
    r = '0;
    r.ep_val = ep_val;
    if (ep_val !== 1'b0) begin
      r.ep_we = ep_we; r.ep_addr = ep_addr; r.ep_data = ep_data;
    end
    r.wr_rdy = wr_rdy;
    r.rd_rdy = rd_rdy;
    r.rd_resp_val = rd_resp_val;
    if (rd_resp_val !== 1'b0) begin
      r.rd_resp_last = rd_resp_last; r.rd_resp_data = rd_resp_data;
    end
    r.busy = busy;
    r.err = err;
    return r;
  endfunction

  task automatic predict(output obs_t x);
    bit wr_el, rd_el, head_rd;
    x = '0;
    wr_el = wr_val && (cred > 0);
    rd_el = active && (issue_left > 0) && (cred > 0);
    p_grd = rd_el && (!wr_el || pref_rd);
    p_gwr = wr_el && !p_grd;
    p_fire = (p_gwr || p_grd) && ep_rdy;
    p_ok = ep_resp_val && (cred < MAXO);
    head_rd = (q_isrd.size() > 0) && q_isrd[0];
    x.ep_val = p_gwr || p_grd;
    if (x.ep_val) begin
      x.ep_we = p_gwr;
      x.ep_addr = p_grd ? next_addr : wr_addr;
      x.ep_data = p_gwr ? wr_data : 32'h0;
    end
    x.wr_rdy = p_gwr && ep_rdy;
    x.rd_rdy = !active;
    if (p_ok && head_rd && rd_order.size() > 0) begin
      x.rd_resp_val = 1'b1;
      x.rd_resp_last = (rd_order.size() == 1);
      x.rd_resp_data = rd_order[0] >> 2;
    end
    x.busy = active || (cred != MAXO);
    x.err = m_err;
  endtask

  task automatic advance();
    bit was_active, drain_done;
    if (reset) begin
      model_reset();
      return;
    end
    was_active = active;
    drain_done = active && (issue_left == 0) && (rd_order.size() == 0);
    if (p_ok) begin
      if (q_isrd[0]) void'(rd_order.pop_front());
      void'(q_isrd.pop_front());
      void'(q_addr.pop_front());
      cred++;
    end
    if (ep_resp_val && !p_ok) m_err = 1;
    if (p_fire) begin
      q_isrd.push_back(p_grd);
      q_addr.push_back(p_grd ? next_addr : wr_addr);
      cred--;
      pref_rd = p_gwr;
      if (p_grd) begin
        next_addr = next_addr + 32'd4;
        issue_left--;
      end
    end
    if (drain_done) active = 0;
    if (!was_active && rd_val && rd_len != 0) begin
      active = 1;
      next_addr = rd_base;
      issue_left = int'(rd_len);
      for (int i = 0; i < int'(rd_len); i++) rd_order.push_back(rd_base + 32'(4 * i));
    end
  endtask

  // Behavioural endpoint: answers the oldest outstanding request with given probability.
  task automatic ep_respond(input int pct);
    ep_resp_val = (q_isrd.size() > 0) && ($urandom_range(0, 99) < pct);
    if (ep_resp_val && q_isrd[0]) ep_resp_data = q_addr[0] >> 2;
    else ep_resp_data = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic idle_inputs();
    wr_val = 0; wr_addr = '0; wr_data = '0;
    rd_val = 0; rd_base = '0; rd_len = '0;
    ep_rdy = 1; ep_resp_val = 0; ep_resp_data = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #2 predict(e); o = observe(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", o, e); end
    n_chk++;
    if (rd_rdy !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy_busy got rd_rdy=%b busy=%b exp 1 0", rd_rdy, busy);
    end
    step();
  endtask

  task automatic test_drain();
    int c;
    idle_inputs();
    for (c = 0; c < 60; c++) begin
      if (!active && q_isrd.size() == 0) break;
      ep_respond(100);
      #2 predict(e); o = observe(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL drain cyc=%0d got=%h exp=%h", c, o, e); end
      step();
    end
    ep_resp_val = 0;
    n_chk++;
    if (c == 60) begin n_fail++; $display("FAIL drain_timeout got busy exp idle within 60 cycles"); end
  endtask

  task automatic test_writes();
    logic [31:0] wa [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] wd [3] = '{32'hA, 32'hB, 32'hC};
    int idx = 0, fires = 0;
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      wr_val = (idx < 3);
      wr_addr = wa[idx < 3 ? idx : 0];
      wr_data = wd[idx < 3 ? idx : 0];
      ep_respond(100);
      #2 predict(e); o = observe(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL writes cyc=%0d got=%h exp=%h", c, o, e); end
      if (ep_val === 1'b1 && ep_we === 1'b1) fires++;
      if (p_gwr && ep_rdy) idx++;
      step();
    end
    n_chk++;
    if (fires != 3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL writes_total got fires=%0d busy=%b exp 3 0", fires, busy);
    end
  endtask

  task automatic test_read_burst();
    int c, nresp = 0, nlast = 0;
    bit launched = 0;
    idle_inputs();
    for (c = 0; c < 40; c++) begin
      if (launched && !active && q_isrd.size() == 0) break;
      rd_val = !launched; rd_base = 32'h200; rd_len = 9'd5;
      ep_respond(100);
      #2 predict(e); o = observe(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL read_burst cyc=%0d got=%h exp=%h", c, o, e); end
      if (rd_resp_val === 1'b1) begin
        nresp++;
        if (rd_resp_last === 1'b1) nlast++;
      end
      step();
      launched = 1;
    end
    n_chk++;
    if (c == 40 || nresp != 5 || nlast != 1) begin
      n_fail++; $display("FAIL read_burst_total got resp=%0d last=%0d exp 5 1", nresp, nlast);
    end
  endtask

  task automatic test_interleave();
    idle_inputs();
    for (int c = 0; c < 30; c++) begin
      wr_val = 1; wr_addr = $urandom & 32'hFFFF_FFFC; wr_data = $urandom;
      rd_val = (c == 0); rd_base = 32'h1000; rd_len = 9'd4;
      ep_rdy = ($urandom_range(0, 3) != 0);
      ep_respond(60);
      #2 predict(e); o = observe(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL interleave cyc=%0d got=%h exp=%h", c, o, e); end
      step();
    end
    test_drain();
  endtask

  task automatic test_credits();
    bit rpat [6] = '{1, 0, 1, 1, 0, 0};
    int fires = 0;
    idle_inputs();
    wr_val = 1;
    for (int c = 0; c < 14; c++) begin
      wr_addr = 32'h3000 + 32'(4 * c); wr_data = $urandom;
      if (c < 8) ep_respond(0);
      else begin
        ep_resp_val = rpat[c - 8] && (q_isrd.size() > 0);
        ep_resp_data = $urandom;
      end
      #2 predict(e); o = observe(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL credits cyc=%0d got=%h exp=%h", c, o, e); end
      if (ep_val === 1'b1 && ep_rdy) fires++;
      step();
      if (c == 7) begin
        n_chk++;
        if (fires != MAXO) begin n_fail++; $display("FAIL credit_limit got fires=%0d exp %0d", fires, MAXO); end
      end
    end
    n_chk++;
    if (fires != MAXO + 3) begin n_fail++; $display("FAIL credit_release got fires=%0d exp %0d", fires, MAXO + 3); end
    test_drain();
  endtask

  task automatic test_zero_len();
    int vals = 0;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      rd_val = (c == 0); rd_base = $urandom & 32'hFFFF_FFFC; rd_len = '0;
      #2 predict(e); o = observe(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL zero_len cyc=%0d got=%h exp=%h", c, o, e); end
      if (ep_val !== 1'b0 || rd_resp_val !== 1'b0) vals++;
      step();
    end
    n_chk++;
    if (vals != 0 || rd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL zero_len_noop got activity=%0d rd_rdy=%b exp 0 1", vals, rd_rdy);
    end
  endtask

  task automatic test_err_and_reset();
    int c;
    idle_inputs();
    for (c = 0; c < 4; c++) begin
      ep_resp_val = (c == 0); ep_resp_data = $urandom;
      #2 predict(e); o = observe(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL err_sticky cyc=%0d got=%h exp=%h", c, o, e); end
      step();
    end
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag got=%b exp 1", err); end
    idle_inputs();
    for (c = 0; c < 20 && q_isrd.size() < 2; c++) begin
      rd_val = (c == 0); rd_base = 32'h400; rd_len = 9'd5;
      #2 predict(e); o = observe(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL burst_pre_reset cyc=%0d got=%h exp=%h", c, o, e); end
      step();
    end
    idle_inputs();
    reset = 1;
    #2 predict(e);
    step();
    reset = 0;
    #2 predict(e); o = observe(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL mid_reset got=%h exp=%h", o, e); end
    n_chk++;
    if (ep_val !== 1'b0 || rd_rdy !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags got ep_val=%b rd_rdy=%b busy=%b err=%b exp 0 1 0 0",
               ep_val, rd_rdy, busy, err);
    end
    step();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 1500; c++) begin
      wr_val = $urandom_range(0, 1);
      wr_addr = $urandom & 32'hFFFF_FFFC; wr_data = $urandom;
      rd_val = ($urandom_range(0, 7) == 0);
      rd_base = $urandom & 32'hFFFF_FFFC; rd_len = 9'($urandom_range(0, 6));
      ep_rdy = ($urandom_range(0, 3) != 0);
      ep_respond(50);
      if (q_isrd.size() == 0 && $urandom_range(0, 199) == 0) ep_resp_val = 1;
      #2 predict(e); o = observe(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", c, o, e); end
      step();
    end
    test_drain();
  endtask

  initial begin
    test_reset();
    test_writes();
    test_read_burst();
    test_interleave();
    test_credits();
    test_zero_len();
    test_err_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion exp finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
